// File: rtl/ifq_pkg.sv
// Shared defaults, entry type and pointer sizing for the instruction fetch queue.
package ifq_pkg;

    localparam int          IFQ_DEPTH    = 4;
    localparam logic [31:0] IFQ_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    function automatic int ifq_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int IFQ_PTR_W = ifq_ptr_w(IFQ_DEPTH);

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of fetched {pc, inst} entries with head/tail pointers and occupancy.
// Flush and reset both empty it; DEPTH must be a power of two so pointers wrap naturally.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_flush,
    input  logic                      i_wr_en,
    input  ifq_entry_t                i_wr_data,
    input  logic                      i_rd_en,
    output ifq_entry_t                o_head,
    output logic [ifq_ptr_w(DEPTH):0] o_count,
    output logic                      o_empty
);

    localparam int             PTR_W      = ifq_ptr_w(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    ifq_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             w_full;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);
    assign w_rd    = i_rd_en && !o_empty;
    assign w_wr    = i_wr_en && (!w_full || w_rd);
    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

    // NOTE: the entry array carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_tail] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_rd) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch sequencer: issues ROM reads, tags returns with their PC and queues them for ID.
// Define IFQ_BYPASS_EN to forward a return straight to the consumer when the queue is empty.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int          DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [6:0]              rom_addr,
    output logic                    rom_req,
    input  logic [31:0]             rom_data,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    input  logic                    deq_ready,
    output logic                    deq_valid,
    output logic [31:0]             deq_inst,
    output logic [31:0]             deq_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int             CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

    logic [31:0]      r_fetch_pc;
    logic [31:0]      r_inflight_pc;
    logic             r_inflight;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_occupancy;
    logic             w_empty;
    logic             w_issue;
    logic             w_bypass;
    logic             w_deq;
    logic             w_wr;
    ifq_entry_t       w_head;
    ifq_entry_t       w_wr_entry;

    // Credit only registered state so a slot freed by this cycle's dequeue is not reused yet.
    assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_issue     = !rst && !redirect && (w_occupancy < DEPTH_LIM);
    assign rom_req     = w_issue;
    assign rom_addr    = r_fetch_pc[8:2];

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_empty && r_inflight;
`else
    assign w_bypass = 1'b0;
`endif

    assign deq_valid  = !rst && (!w_empty || w_bypass);
    assign deq_inst   = w_bypass ? rom_data : w_head.inst;
    assign deq_pc     = w_bypass ? r_inflight_pc : w_head.pc;
    assign w_deq      = deq_valid && deq_ready;
    assign w_wr       = r_inflight && !redirect && !(w_bypass && deq_ready);
    assign w_wr_entry = '{pc: r_inflight_pc, inst: rom_data};
    assign count      = w_count;

    // NOTE: registered state is updated only with non-blocking assignments to avoid ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (redirect),
        .i_wr_en   (w_wr),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_deq && !w_bypass),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_empty   (w_empty)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, a stall sequence, and a randomized
// run against a queue-based reference model. Honours IFQ_BYPASS_EN when defined.
module tb_inst_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic [6:0]             rom_addr;
    logic                   rom_req;
    logic [31:0]            rom_data;
    logic                   redirect;
    logic [31:0]            redirect_pc;
    logic                   deq_ready;
    logic                   deq_valid;
    logic [31:0]            deq_inst;
    logic [31:0]            deq_pc;
    logic [$clog2(DEPTH):0] count;

    inst_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_req     (rom_req),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .deq_ready   (deq_ready),
        .deq_valid   (deq_valid),
        .deq_inst    (deq_inst),
        .deq_pc      (deq_pc),
        .count       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] rom_next = 32'h0;

    // Distinct word per ROM address so a wrong pc/inst pairing is visible.
    function automatic logic [31:0] rom_word(input logic [6:0] a);
        return {8'hE5, 1'b0, a, 1'b1, ~a, 1'b0, a ^ 7'h2A};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One cycle: drive inputs mid-cycle, let combinational outputs settle, latch the ROM reply.
    task automatic step(input bit r, input bit d, input logic [31:0] rp, input bit rdy);
        @(negedge clk);
        rst         = r;
        redirect    = d;
        redirect_pc = rp;
        deq_ready   = rdy;
        rom_data    = rom_next;
        #1;
        rom_next = rom_word(rom_addr);
    endtask

    task automatic check_outputs(input string tag, input bit e_req, input logic [6:0] e_addr,
                                 input bit e_valid, input logic [31:0] e_pc, input int e_count);
        check({tag, ".rom_req"}, 32'(rom_req), 32'(e_req));
        if (e_req) check({tag, ".rom_addr"}, 32'(rom_addr), 32'(e_addr));
        check({tag, ".deq_valid"}, 32'(deq_valid), 32'(e_valid));
        if (e_valid) begin
            check({tag, ".deq_pc"}, deq_pc, e_pc);
            check({tag, ".deq_inst"}, deq_inst, rom_word(e_pc[8:2]));
        end
        check({tag, ".count"}, 32'(count), 32'(e_count));
    endtask

    typedef struct {
        bit          rst;
        bit          redir;
        logic [31:0] rpc;
        bit          rdy;
        bit          e_req;
        logic [6:0]  e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        int          e_count;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit r, input bit d, input logic [31:0] rp, input bit rdy,
                           input bit q, input logic [6:0] a, input bit v,
                           input logic [31:0] p, input int c);
        vec_t t;
        t.rst = r; t.redir = d; t.rpc = rp; t.rdy = rdy;
        t.e_req = q; t.e_addr = a; t.e_valid = v; t.e_pc = p; t.e_count = c;
        vecs.push_back(t);
    endtask

    // Reference model: a queue of PCs plus one pending ROM return.
    logic [31:0] m_q[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_fetch;

    task automatic model_reset();
        m_q.delete();
        m_pend    = 1'b0;
        m_pend_pc = RESET_PC;
        m_fetch   = RESET_PC;
    endtask

    task automatic model_cycle(input string tag, input bit r, input bit d,
                               input logic [31:0] rp, input bit rdy);
        bit          e_req;
        bit          e_valid;
        bit          deq;
        logic [31:0] e_pc;
        e_req   = !r && !d && (m_q.size() + int'(m_pend) < DEPTH);
        e_valid = !r && (m_q.size() > 0 || (BYPASS && m_pend));
        e_pc    = (m_q.size() > 0) ? m_q[0] : m_pend_pc;
        check_outputs(tag, e_req, m_fetch[8:2], e_valid, e_pc, m_q.size());
        if (r) begin
            model_reset();
        end else begin
            deq = e_valid && rdy;
            if (m_q.size() > 0) begin
                if (deq) void'(m_q.pop_front());
                if (m_pend && !d) m_q.push_back(m_pend_pc);
            end else if (m_pend && !d && !(BYPASS && deq)) begin
                m_q.push_back(m_pend_pc);
            end
            if (d) begin
                m_q.delete();
                m_pend  = 1'b0;
                m_fetch = rp;
            end else begin
                m_pend = e_req;
                if (e_req) begin
                    m_pend_pc = m_fetch;
                    m_fetch   = m_fetch + 32'd4;
                end
            end
        end
    endtask

    initial begin
        int n_req;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b0; rom_data = 32'h0;

        //        rst red rpc           rdy req addr    val pc            cnt
`ifdef IFQ_BYPASS_EN
        add_vec(1, 0, 32'h0,        1, 0, 7'h00, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h00, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h01, 1, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h02, 1, 32'h4,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h03, 1, 32'h8,        0);
        add_vec(0, 0, 32'h0,        0, 1, 7'h04, 1, 32'hC,        0);
        add_vec(0, 0, 32'h0,        0, 1, 7'h05, 1, 32'hC,        1);
        add_vec(0, 0, 32'h0,        1, 1, 7'h06, 1, 32'hC,        2);
        add_vec(0, 1, 32'h40,       1, 0, 7'h00, 1, 32'h10,       2);
        add_vec(0, 0, 32'h0,        1, 1, 7'h10, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h11, 1, 32'h40,       0);
        add_vec(1, 0, 32'h0,        1, 0, 7'h00, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h00, 0, 32'h0,        0);
`else
        add_vec(1, 0, 32'h0,        1, 0, 7'h00, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h00, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h01, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h02, 1, 32'h0,        1);
        add_vec(0, 0, 32'h0,        1, 1, 7'h03, 1, 32'h4,        1);
        add_vec(0, 0, 32'h0,        1, 1, 7'h04, 1, 32'h8,        1);
        add_vec(0, 0, 32'h0,        0, 1, 7'h05, 1, 32'hC,        1);
        add_vec(0, 0, 32'h0,        0, 1, 7'h06, 1, 32'hC,        2);
        add_vec(0, 0, 32'h0,        0, 0, 7'h00, 1, 32'hC,        3);
        add_vec(0, 0, 32'h0,        0, 0, 7'h00, 1, 32'hC,        4);
        add_vec(0, 0, 32'h0,        0, 0, 7'h00, 1, 32'hC,        4);
        add_vec(0, 0, 32'h0,        1, 0, 7'h00, 1, 32'hC,        4);
        add_vec(0, 1, 32'h40,       0, 0, 7'h00, 1, 32'h10,       3);
        add_vec(0, 0, 32'h0,        1, 1, 7'h10, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h11, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h12, 1, 32'h40,       1);
        add_vec(0, 1, 32'h100,      1, 0, 7'h00, 1, 32'h44,       1);
        add_vec(0, 0, 32'h0,        1, 1, 7'h40, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h41, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        0, 1, 7'h42, 1, 32'h100,      1);
        add_vec(1, 0, 32'h0,        0, 0, 7'h00, 0, 32'h0,        2);
        add_vec(0, 0, 32'h0,        1, 1, 7'h00, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h01, 0, 32'h0,        0);
        add_vec(0, 0, 32'h0,        1, 1, 7'h02, 1, 32'h0,        1);
`endif

        step(1, 0, 32'h0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                          vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_count);
        end

        // Consumer stalled after reset: the queue fills with exactly DEPTH fetches.
        step(1, 0, 32'h0, 0);
        n_req = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 32'h0, 0);
            if (rom_req) n_req++;
            if (deq_valid) check($sformatf("hold%0d.deq_pc", k), deq_pc, 32'h0);
        end
        check("hold.req_total", 32'(n_req), 32'd4);
        check("hold.count", 32'(count), 32'd4);
        check("hold.rom_req", 32'(rom_req), 32'd0);

        // Randomized traffic against the reference model.
        step(1, 0, 32'h0, 0);
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          r;
            bit          d;
            bit          rdy;
            logic [31:0] rp;
            r   = ($urandom_range(0, 99) < 2);
            d   = ($urandom_range(0, 99) < 8);
            rdy = ($urandom_range(0, 3) != 0);
            rp  = $urandom() & 32'hFFFF_FFFC;
            step(r, d, rp, rdy);
            model_cycle($sformatf("rnd%0d", cyc), r, d, rp, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
